// File: rtl/dcache_mem_controller_pkg.sv
// rtl/dcache_mem_controller_pkg.sv - shared types and widths for the dcache memory controller
package dcache_mem_pkg;

    localparam int NUM_CONSUMERS_DEFAULT = 8;

    // Index width for a consumer count; never below one bit so single-port builds still elaborate.
    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int CONSUMER_IDX_BITS = idx_bits(NUM_CONSUMERS_DEFAULT);

    typedef enum logic [2:0] {
        CH_IDLE        = 3'd0,
        CH_READ_WAIT   = 3'd1,
        CH_WRITE_WAIT  = 3'd2,
        CH_READ_RELAY  = 3'd3,
        CH_WRITE_RELAY = 3'd4
    } ch_state_e;

endpackage

// File: rtl/dcache_mem_controller_if.sv
// rtl/dcache_mem_controller_if.sv - dcache request ports and memory channel bus
interface dcache_mem_controller_if #(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 8,
    parameter int NUM_CONSUMERS = 8,
    parameter int NUM_CHANNELS  = 2
) ();

    logic [NUM_CONSUMERS-1:0]                consumer_read_valid;
    logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_read_address;
    logic [NUM_CONSUMERS-1:0]                consumer_read_ready;
    logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_read_data;
    logic [NUM_CONSUMERS-1:0]                consumer_write_valid;
    logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_write_address;
    logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_write_data;
    logic [NUM_CONSUMERS-1:0]                consumer_write_ready;

    logic [NUM_CHANNELS-1:0]                 mem_read_valid;
    logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_read_address;
    logic [NUM_CHANNELS-1:0]                 mem_read_ready;
    logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_read_data;
    logic [NUM_CHANNELS-1:0]                 mem_write_valid;
    logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_write_address;
    logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_write_data;
    logic [NUM_CHANNELS-1:0]                 mem_write_ready;

    // Controller view: responds to the dcache, issues to memory.
    modport slave (
        input  consumer_read_valid, consumer_read_address,
        input  consumer_write_valid, consumer_write_address, consumer_write_data,
        input  mem_read_ready, mem_read_data, mem_write_ready,
        output consumer_read_ready, consumer_read_data, consumer_write_ready,
        output mem_read_valid, mem_read_address,
        output mem_write_valid, mem_write_address, mem_write_data
    );

    // Environment view: the dcache requesters plus the external memory.
    modport master (
        output consumer_read_valid, consumer_read_address,
        output consumer_write_valid, consumer_write_address, consumer_write_data,
        output mem_read_ready, mem_read_data, mem_write_ready,
        input  consumer_read_ready, consumer_read_data, consumer_write_ready,
        input  mem_read_valid, mem_read_address,
        input  mem_write_valid, mem_write_address, mem_write_data
    );

endinterface

// File: rtl/dcache_mem_controller_channel.sv
// rtl/dcache_mem_controller_channel.sv - one memory channel: claim, wait on memory, relay to consumer
module dcache_mem_channel
    import dcache_mem_pkg::*;
#(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 8,
    parameter int NUM_CONSUMERS = 8,
    parameter int IDX_BITS      = CONSUMER_IDX_BITS
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     claim_i,
    input  logic                     claim_read_i,
    input  logic [IDX_BITS-1:0]      claim_idx_i,
    input  logic [ADDR_BITS-1:0]     claim_addr_i,
    input  logic [DATA_BITS-1:0]     claim_data_i,
    input  logic [NUM_CONSUMERS-1:0] consumer_read_valid_i,
    input  logic [NUM_CONSUMERS-1:0] consumer_write_valid_i,
    input  logic                     mem_read_ready_i,
    input  logic                     mem_write_ready_i,
    output logic                     idle_o,
    output logic                     rd_done_o,
    output logic                     wr_done_o,
    output logic                     release_o,
    output logic [IDX_BITS-1:0]      idx_o,
    output logic                     mem_read_valid_o,
    output logic [ADDR_BITS-1:0]     mem_read_address_o,
    output logic                     mem_write_valid_o,
    output logic [ADDR_BITS-1:0]     mem_write_address_o,
    output logic [DATA_BITS-1:0]     mem_write_data_o
);

    ch_state_e            state_q;
    logic [IDX_BITS-1:0]  idx_q;
    logic                 rd_valid_q;
    logic [ADDR_BITS-1:0] rd_addr_q;
    logic                 wr_valid_q;
    logic [ADDR_BITS-1:0] wr_addr_q;
    logic [DATA_BITS-1:0] wr_data_q;

    // Memory ready only counts while waiting; relay ends once the served consumer drops its valid.
    assign idle_o    = (state_q == CH_IDLE);
    assign rd_done_o = (state_q == CH_READ_WAIT)  && mem_read_ready_i;
    assign wr_done_o = (state_q == CH_WRITE_WAIT) && mem_write_ready_i;
    assign release_o = ((state_q == CH_READ_RELAY)  && !consumer_read_valid_i[idx_q]) ||
                       ((state_q == CH_WRITE_RELAY) && !consumer_write_valid_i[idx_q]);
    assign idx_o     = idx_q;

    assign mem_read_valid_o    = rd_valid_q;
    assign mem_read_address_o  = rd_addr_q;
    assign mem_write_valid_o   = wr_valid_q;
    assign mem_write_address_o = wr_addr_q;
    assign mem_write_data_o    = wr_data_q;

    // Channel FSM with registered memory-side request outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= CH_IDLE;
            idx_q      <= '0;
            rd_valid_q <= 1'b0;
            rd_addr_q  <= '0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            case (state_q)
                CH_IDLE: begin
                    if (claim_i) begin
                        idx_q <= claim_idx_i;
                        if (claim_read_i) begin
                            rd_valid_q <= 1'b1;
                            rd_addr_q  <= claim_addr_i;
                            state_q    <= CH_READ_WAIT;
                        end else begin
                            wr_valid_q <= 1'b1;
                            wr_addr_q  <= claim_addr_i;
                            wr_data_q  <= claim_data_i;
                            state_q    <= CH_WRITE_WAIT;
                        end
                    end
                end
                CH_READ_WAIT: begin
                    if (rd_done_o) begin
                        rd_valid_q <= 1'b0;
                        state_q    <= CH_READ_RELAY;
                    end
                end
                CH_WRITE_WAIT: begin
                    if (wr_done_o) begin
                        wr_valid_q <= 1'b0;
                        state_q    <= CH_WRITE_RELAY;
                    end
                end
                CH_READ_RELAY, CH_WRITE_RELAY: begin
                    if (release_o) begin
                        state_q <= CH_IDLE;
                    end
                end
                default: state_q <= CH_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/dcache_mem_controller.sv
// rtl/dcache_mem_controller.sv - arbitrates dcache read/write requests onto memory channels
module dcache_mem_controller
    import dcache_mem_pkg::*;
#(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 8,
    parameter int NUM_CONSUMERS = NUM_CONSUMERS_DEFAULT,
    parameter int NUM_CHANNELS  = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    dcache_mem_controller_if.slave  bus
);

    localparam int IDX_BITS = idx_bits(NUM_CONSUMERS);

    logic [NUM_CONSUMERS-1:0]                serving_q;
    logic [NUM_CONSUMERS-1:0]                rd_ready_q;
    logic [NUM_CONSUMERS-1:0]                wr_ready_q;
    logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] rd_data_q;

    logic [NUM_CONSUMERS-1:0] avail;
    logic [NUM_CHANNELS-1:0]  claim_v;
    logic [NUM_CHANNELS-1:0]  claim_rd;
    logic [IDX_BITS-1:0]      claim_idx  [NUM_CHANNELS];
    logic [ADDR_BITS-1:0]     claim_addr [NUM_CHANNELS];
    logic [DATA_BITS-1:0]     claim_data [NUM_CHANNELS];

    logic                     ch_idle [NUM_CHANNELS];
    logic                     rd_done [NUM_CHANNELS];
    logic                     wr_done [NUM_CHANNELS];
    logic                     ch_rel  [NUM_CHANNELS];
    logic [IDX_BITS-1:0]      ch_idx  [NUM_CHANNELS];
    logic                     m_rv    [NUM_CHANNELS];
    logic [ADDR_BITS-1:0]     m_ra    [NUM_CHANNELS];
    logic                     m_wv    [NUM_CHANNELS];
    logic [ADDR_BITS-1:0]     m_wa    [NUM_CHANNELS];
    logic [DATA_BITS-1:0]     m_wd    [NUM_CHANNELS];

    // Claim chain: each idle channel takes the lowest pending unserved consumer, hiding it from later channels.
    always_comb begin
        avail = (bus.consumer_read_valid | bus.consumer_write_valid) & ~serving_q;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            claim_v[c]   = 1'b0;
            claim_rd[c]  = 1'b0;
            claim_idx[c] = '0;
            if (ch_idle[c]) begin
                for (int i = 0; i < NUM_CONSUMERS; i++) begin
                    if (!claim_v[c] && avail[i]) begin
                        claim_v[c]   = 1'b1;
                        claim_idx[c] = IDX_BITS'(i);
                        claim_rd[c]  = bus.consumer_read_valid[i];
                    end
                end
            end
            if (claim_v[c]) begin
                avail[claim_idx[c]] = 1'b0;
            end
        end
    end

    // Select the claimed consumer's address/data; read takes priority over write.
    always_comb begin
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            claim_addr[c] = claim_rd[c] ? bus.consumer_read_address[claim_idx[c]]
                                        : bus.consumer_write_address[claim_idx[c]];
            claim_data[c] = bus.consumer_write_data[claim_idx[c]];
        end
    end

    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
        dcache_mem_channel #(
            .ADDR_BITS     (ADDR_BITS),
            .DATA_BITS     (DATA_BITS),
            .NUM_CONSUMERS (NUM_CONSUMERS),
            .IDX_BITS      (IDX_BITS)
        ) u_ch (
            .clk                    (clk),
            .reset                  (reset),
            .claim_i                (claim_v[c]),
            .claim_read_i           (claim_rd[c]),
            .claim_idx_i            (claim_idx[c]),
            .claim_addr_i           (claim_addr[c]),
            .claim_data_i           (claim_data[c]),
            .consumer_read_valid_i  (bus.consumer_read_valid),
            .consumer_write_valid_i (bus.consumer_write_valid),
            .mem_read_ready_i       (bus.mem_read_ready[c]),
            .mem_write_ready_i      (bus.mem_write_ready[c]),
            .idle_o                 (ch_idle[c]),
            .rd_done_o              (rd_done[c]),
            .wr_done_o              (wr_done[c]),
            .release_o              (ch_rel[c]),
            .idx_o                  (ch_idx[c]),
            .mem_read_valid_o       (m_rv[c]),
            .mem_read_address_o     (m_ra[c]),
            .mem_write_valid_o      (m_wv[c]),
            .mem_write_address_o    (m_wa[c]),
            .mem_write_data_o       (m_wd[c])
        );
    end

    // Gather per-channel memory requests onto the bus.
    always_comb begin
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            bus.mem_read_valid[c]    = m_rv[c];
            bus.mem_read_address[c]  = m_ra[c];
            bus.mem_write_valid[c]   = m_wv[c];
            bus.mem_write_address[c] = m_wa[c];
            bus.mem_write_data[c]    = m_wd[c];
        end
    end

    // Serving mask and per-consumer ack/data; read data stays put after ready falls.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            serving_q  <= '0;
            rd_ready_q <= '0;
            wr_ready_q <= '0;
            rd_data_q  <= '0;
        end else begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                if (claim_v[c]) begin
                    serving_q[claim_idx[c]] <= 1'b1;
                end
                if (rd_done[c]) begin
                    rd_ready_q[ch_idx[c]] <= 1'b1;
                    rd_data_q[ch_idx[c]]  <= bus.mem_read_data[c];
                end
                if (wr_done[c]) begin
                    wr_ready_q[ch_idx[c]] <= 1'b1;
                end
                if (ch_rel[c]) begin
                    serving_q[ch_idx[c]]  <= 1'b0;
                    rd_ready_q[ch_idx[c]] <= 1'b0;
                    wr_ready_q[ch_idx[c]] <= 1'b0;
                end
            end
        end
    end

    assign bus.consumer_read_ready  = rd_ready_q;
    assign bus.consumer_write_ready = wr_ready_q;
    assign bus.consumer_read_data   = rd_data_q;

endmodule

// File: tb/tb_dcache_mem_controller.sv
// tb/tb_dcache_mem_controller.sv - directed scoreboard bench for dcache_mem_controller
module tb_dcache_mem_controller;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    dcache_mem_controller_if bus ();

    dcache_mem_controller #(
        .ADDR_BITS     (8),
        .DATA_BITS     (8),
        .NUM_CONSUMERS (8),
        .NUM_CHANNELS  (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int         cons;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_rrdy"},  64'(bus.consumer_read_ready),  64'd0);
        chk({tag, "_wrdy"},  64'(bus.consumer_write_ready), 64'd0);
        chk({tag, "_rdata"}, 64'(bus.consumer_read_data),   64'd0);
        chk({tag, "_mrv"},   64'(bus.mem_read_valid),       64'd0);
        chk({tag, "_mwv"},   64'(bus.mem_write_valid),      64'd0);
        chk({tag, "_maddr"}, 64'({bus.mem_read_address, bus.mem_write_address, bus.mem_write_data}), 64'd0);
    endtask

    // Memory model returns data on a channel; the consumer it is bound for is expected to see it.
    task automatic mem_read(input int ch, input int cons, input logic [7:0] d);
        bus.mem_read_ready[ch] = 1'b1;
        bus.mem_read_data[ch]  = d;
        exp_q.push_back('{cons: cons, data: d});
    endtask

    task automatic expect_rdata(input int cons);
        exp_t e;
        chk("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("sb_cons", 64'(cons), 64'(e.cons));
            chk("sb_rdata", 64'(bus.consumer_read_data[cons]), 64'(e.data));
        end
    endtask

    task automatic clear_inputs();
        bus.consumer_read_valid    = '0;
        bus.consumer_read_address  = '0;
        bus.consumer_write_valid   = '0;
        bus.consumer_write_address = '0;
        bus.consumer_write_data    = '0;
        bus.mem_read_ready         = '0;
        bus.mem_read_data          = '0;
        bus.mem_write_ready        = '0;
    endtask

    initial begin
        clear_inputs();
        reset = 1'b0;

        // 1: reset dominates active requests and memory readies
        bus.consumer_read_valid  = '1;
        bus.consumer_write_valid = '1;
        bus.consumer_read_address[0] = 8'h12;
        bus.mem_read_ready  = '1;
        bus.mem_write_ready = '1;
        bus.mem_read_data[0] = 8'hAB;
        tick();
        tick();
        chk_quiet("rst");
        clear_inputs();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_quiet("idle");
        end

        // 2: single read on consumer 0
        bus.consumer_read_valid[0]   = 1'b1;
        bus.consumer_read_address[0] = 8'hFF;
        tick();
        chk("t2_mrv",   64'(bus.mem_read_valid), 64'h1);
        chk("t2_maddr", 64'(bus.mem_read_address[0]), 64'hFF);
        chk("t2_rrdy0", 64'(bus.consumer_read_ready), 64'h0);
        mem_read(0, 0, 8'hFF);
        tick();
        bus.mem_read_ready = '0;
        chk("t2_rrdy",  64'(bus.consumer_read_ready), 64'h01);
        expect_rdata(0);
        chk("t2_mrv_off", 64'(bus.mem_read_valid), 64'h0);
        bus.consumer_read_valid[0] = 1'b0;
        tick();
        chk("t2_rrdy_fall", 64'(bus.consumer_read_ready), 64'h0);
        chk("t2_rdata_keep", 64'(bus.consumer_read_data[0]), 64'hFF);
        chk("t2_quiet", 64'({bus.mem_read_valid, bus.mem_write_valid}), 64'h0);

        // 3: concurrent read on consumer 0 and write on consumer 1
        bus.consumer_read_valid[0]    = 1'b1;
        bus.consumer_read_address[0]  = 8'hFF;
        bus.consumer_write_valid[1]   = 1'b1;
        bus.consumer_write_address[1] = 8'hF0;
        bus.consumer_write_data[1]    = 8'hF0;
        tick();
        chk("t3_mrv",   64'(bus.mem_read_valid), 64'h1);
        chk("t3_mwv",   64'(bus.mem_write_valid), 64'h2);
        chk("t3_raddr", 64'(bus.mem_read_address[0]), 64'hFF);
        chk("t3_waddr", 64'(bus.mem_write_address[1]), 64'hF0);
        chk("t3_wdata", 64'(bus.mem_write_data[1]), 64'hF0);
        mem_read(0, 0, 8'h3C);
        bus.mem_write_ready[1] = 1'b1;
        tick();
        bus.mem_read_ready  = '0;
        bus.mem_write_ready = '0;
        chk("t3_rrdy", 64'(bus.consumer_read_ready), 64'h01);
        chk("t3_wrdy", 64'(bus.consumer_write_ready), 64'h02);
        expect_rdata(0);
        chk("t3_mem_off", 64'({bus.mem_read_valid, bus.mem_write_valid}), 64'h0);
        bus.consumer_read_valid[0]  = 1'b0;
        bus.consumer_write_valid[1] = 1'b0;
        tick();
        chk("t3_rel", 64'({bus.consumer_read_ready, bus.consumer_write_ready}), 64'h0);

        // 4: three readers on two channels; consumer 7 waits for a free channel
        bus.consumer_read_valid[2] = 1'b1; bus.consumer_read_address[2] = 8'h22;
        bus.consumer_read_valid[5] = 1'b1; bus.consumer_read_address[5] = 8'h55;
        bus.consumer_read_valid[7] = 1'b1; bus.consumer_read_address[7] = 8'h77;
        tick();
        chk("t4_mrv",    64'(bus.mem_read_valid), 64'h3);
        chk("t4_addr0",  64'(bus.mem_read_address[0]), 64'h22);
        chk("t4_addr1",  64'(bus.mem_read_address[1]), 64'h55);
        mem_read(1, 5, 8'hC5);
        tick();
        bus.mem_read_ready = '0;
        chk("t4_rrdy5", 64'(bus.consumer_read_ready), 64'h20);
        expect_rdata(5);
        chk("t4_hold7", 64'(bus.mem_read_valid), 64'h1);
        bus.consumer_read_valid[5] = 1'b0;
        tick();
        chk("t4_rel5", 64'(bus.consumer_read_ready), 64'h0);
        chk("t4_not_yet", 64'(bus.mem_read_valid), 64'h1);
        tick();
        chk("t4_mrv7",  64'(bus.mem_read_valid), 64'h3);
        chk("t4_addr7", 64'(bus.mem_read_address[1]), 64'h77);
        mem_read(0, 2, 8'h11);
        mem_read(1, 7, 8'h99);
        tick();
        bus.mem_read_ready = '0;
        chk("t4_rrdy27", 64'(bus.consumer_read_ready), 64'h84);
        expect_rdata(2);
        expect_rdata(7);
        bus.consumer_read_valid = '0;
        tick();
        chk("t4_rel", 64'(bus.consumer_read_ready), 64'h0);

        // 5: consumer 3 keeps valid high after ready; ack and data hold, no reissue
        bus.consumer_read_valid[3]   = 1'b1;
        bus.consumer_read_address[3] = 8'h33;
        tick();
        chk("t5_mrv",  64'(bus.mem_read_valid), 64'h1);
        chk("t5_addr", 64'(bus.mem_read_address[0]), 64'h33);
        mem_read(0, 3, 8'h5A);
        tick();
        bus.mem_read_ready = '0;
        chk("t5_rrdy", 64'(bus.consumer_read_ready), 64'h08);
        expect_rdata(3);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t5_hold_rdy",  64'(bus.consumer_read_ready), 64'h08);
            chk("t5_hold_data", 64'(bus.consumer_read_data[3]), 64'h5A);
            chk("t5_no_mem",    64'(bus.mem_read_valid), 64'h0);
        end
        bus.consumer_read_valid[3] = 1'b0;
        tick();
        chk("t5_rel",  64'(bus.consumer_read_ready), 64'h0);
        chk("t5_keep", 64'(bus.consumer_read_data[3]), 64'h5A);

        // 6: asynchronous reset in READ_WAIT, then clean reissue of the held request
        bus.consumer_read_valid[4]   = 1'b1;
        bus.consumer_read_address[4] = 8'h44;
        tick();
        chk("t6_mrv", 64'(bus.mem_read_valid), 64'h1);
        #2;
        reset = 1'b0;
        #1;
        chk_quiet("t6_async");
        tick();
        reset = 1'b1;
        tick();
        chk("t6_reissue", 64'(bus.mem_read_valid), 64'h1);
        chk("t6_addr",    64'(bus.mem_read_address[0]), 64'h44);
        mem_read(0, 4, 8'h77);
        tick();
        bus.mem_read_ready = '0;
        chk("t6_rrdy", 64'(bus.consumer_read_ready), 64'h10);
        expect_rdata(4);
        bus.consumer_read_valid[4] = 1'b0;
        tick();
        chk("t6_rel", 64'(bus.consumer_read_ready), 64'h0);
        chk("t6_sb_drained", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
